arduino_rx_port: RTL and testbench

ARDUINO_RX_PORT -- requirements
Module: arduino_rx_port

---
 rtl/arduino_rx_port.sv | 166 ++++++++++++++++
 tb/tb_arduino_rx_port.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_rx_port.sv
`default_nettype none
// ============================================================================
//  Module   : arduino_rx_port
//  Purpose  : Receives bytes from an Arduino over a four-phase REQ/ACK
//             handshake, queues them in a small FIFO, and exposes head data
//             and status to the MCU through its port-mapped I/O bus.
//  Revision : 1.0  initial release
// ============================================================================
module arduino_rx_port #(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] DATA_ID = 8'h97,
    parameter logic [7:0] STAT_ID = 8'h98
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] ARD_DATA,
    input  logic       ARD_REQ,
    output logic       ARD_ACK,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTR
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_LOW = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_ack;
    logic                r_req_meta;
    logic                r_req_s;
    logic                r_strb_prev;
    logic [7:0]          r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [1:0]          r_intr_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_strb_rise;
    logic                w_flush;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [4:0]          w_cnt5;
    logic [7:0]          w_in_port;
    logic                w_unused_out;

    assign w_full      = (r_count == c_cnt_w'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_strb_rise = IO_STRB & ~r_strb_prev;
    assign w_flush     = w_strb_rise && (PORT_ID == STAT_ID) && OUT_PORT[0];
    // The handshake completes even when a flush drops the byte, so the
    // Arduino is never left stalled.
    assign w_accept    = (r_state == ST_IDLE) && r_req_s && !w_full;
    assign w_push      = w_accept && !w_flush;
    assign w_pop       = w_strb_rise && (PORT_ID == DATA_ID) && !w_empty;
    assign w_cnt5      = 5'(r_count);
    assign w_unused_out = &{1'b0, OUT_PORT[7:1]};

    assign ARD_ACK = r_ack;
    assign INTR    = (r_intr_cnt != 2'd0);
    assign IN_PORT = w_in_port;

    // Two-flop synchronizer for REQ and previous-value flop for strobe edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_req_meta  <= 1'b0;
            r_req_s     <= 1'b0;
            r_strb_prev <= 1'b0;
        end else begin
            r_req_meta  <= ARD_REQ;
            r_req_s     <= r_req_meta;
            r_strb_prev <= IO_STRB;
        end
    end

    // Four-phase handshake FSM; ACK is high exactly while in WAIT_LOW
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_WAIT_LOW;
                        r_ack   <= 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!r_req_s) begin
                        r_state <= ST_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle activity
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since reads are gated by empty
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ARD_DATA;
        end
    end

    // Two-cycle interrupt pulse on the empty-to-nonempty transition
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_intr_cnt <= 2'd0;
        end else if (w_push && w_empty) begin
            r_intr_cnt <= 2'd2;
        end else if (r_intr_cnt != 2'd0) begin
            r_intr_cnt <= r_intr_cnt - 2'd1;
        end
    end

    // Read mux toward the MCU input port
    always_comb begin
        w_in_port = 8'h00;
        if (PORT_ID == DATA_ID) begin
            w_in_port = w_empty ? 8'h00 : r_mem[r_rd_ptr];
        end else if (PORT_ID == STAT_ID) begin
            w_in_port = {w_full, w_empty, 1'b0, w_cnt5};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arduino_rx_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arduino_rx_port
//  Purpose  : Self-checking bench for arduino_rx_port (scoreboard + monitor)
//  Revision : 1.0  initial release
// ============================================================================
module tb_arduino_rx_port;

    localparam logic [7:0] DID = 8'h97;
    localparam logic [7:0] SID = 8'h98;
    localparam int SEL_IN   = 0;
    localparam int SEL_ACK  = 1;
    localparam int SEL_INTR = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] ARD_DATA = 8'h00;
    logic       ARD_REQ = 1'b0;
    logic       ARD_ACK;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] IN_PORT;
    logic       INTR;

    always #5 CLK = ~CLK;

    arduino_rx_port #(.DEPTH(4), .DATA_ID(DID), .STAT_ID(SID)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ARD_DATA (ARD_DATA),
        .ARD_REQ  (ARD_REQ),
        .ARD_ACK  (ARD_ACK),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_PORT  (IN_PORT),
        .INTR     (INTR)
    );

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every negedge, compare all expectations queued this cycle
    always @(negedge CLK) begin
        chk_t       c;
        logic [7:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.sel)
                SEL_IN:  act = IN_PORT;
                SEL_ACK: act = {7'b0, ARD_ACK};
                default: act = {7'b0, INTR};
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h (t=%0t)", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_v(input int sel, input logic [7:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    // One IN_PORT read per cycle, since PORT_ID selects what is observed
    task automatic rd(input logic [7:0] id, input logic [7:0] exp, input string name);
        PORT_ID = id;
        expect_v(SEL_IN, exp, name);
        tick(1);
    endtask

    task automatic strobe(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        tick(2);
        IO_STRB  = 1'b0;
        OUT_PORT = 8'h00;
    endtask

    // Bounded wait for ACK level; the final check fails if it never arrives
    task automatic wait_ack(input logic lvl, input string name);
        for (int i = 0; i < 16; i++) begin
            if (ARD_ACK === lvl) break;
            tick(1);
        end
        expect_v(SEL_ACK, {7'b0, lvl}, name);
    endtask

    task automatic send_byte(input logic [7:0] d, input string name);
        ARD_DATA = d;
        ARD_REQ  = 1'b1;
        wait_ack(1'b1, name);
        ARD_REQ  = 1'b0;
        wait_ack(1'b0, name);
    endtask

    // Push (REQ) and pop (strobe) land on the same clock edge
    task automatic push_pop(input logic [7:0] d, input string name);
        ARD_DATA = d;
        ARD_REQ  = 1'b1;
        tick(2);
        PORT_ID  = DID;
        IO_STRB  = 1'b1;
        tick(1);
        expect_v(SEL_ACK, 8'h01, name);
        tick(1);
        IO_STRB  = 1'b0;
        ARD_REQ  = 1'b0;
        wait_ack(1'b0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(2);
        expect_v(SEL_ACK, 8'h00, "rst_ack");
        expect_v(SEL_INTR, 8'h00, "rst_intr");
        rd(SID, 8'h40, "rst_status");
        rd(DID, 8'h00, "rst_data");
        rd(8'h12, 8'h00, "rst_other_id");
        checks++;
        if (ARD_ACK !== 1'b0) begin
            errors++;
            $display("FAIL rst_direct_ack: got %b, expected 0", ARD_ACK);
        end
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL rst_direct_intr: got %b, expected 0", INTR);
        end
        RST_N = 1'b1;
        tick(2);

        // Single byte A5: ACK after three edges, two-cycle INTR
        ARD_DATA = 8'hA5;
        ARD_REQ  = 1'b1;
        PORT_ID  = SID;
        tick(1);
        expect_v(SEL_ACK, 8'h00, "a5_ack_e1");
        tick(1);
        expect_v(SEL_ACK, 8'h00, "a5_ack_e2");
        expect_v(SEL_INTR, 8'h00, "a5_intr_pre");
        tick(1);
        expect_v(SEL_ACK, 8'h01, "a5_ack_e3");
        expect_v(SEL_INTR, 8'h01, "a5_intr_c1");
        expect_v(SEL_IN, 8'h01, "a5_status");   // full=0 empty=0 count=1
        tick(1);
        expect_v(SEL_INTR, 8'h01, "a5_intr_c2");
        PORT_ID = DID;
        expect_v(SEL_IN, 8'hA5, "a5_head");
        tick(1);
        expect_v(SEL_INTR, 8'h00, "a5_intr_end");
        ARD_REQ = 1'b0;
        wait_ack(1'b0, "a5_ack_low");
        strobe(DID, 8'h00);
        rd(SID, 8'h40, "a5_after_pop");

        // Fill to DEPTH, fifth byte stalls until a pop frees a slot
        for (int i = 1; i <= 4; i++) send_byte(8'(i), "fill_ack");
        ARD_DATA = 8'h05;
        ARD_REQ  = 1'b1;
        tick(6);
        expect_v(SEL_ACK, 8'h00, "full_no_ack");
        rd(SID, 8'h84, "full_status");
        rd(DID, 8'h01, "full_head");
        strobe(DID, 8'h00);
        expect_v(SEL_ACK, 8'h01, "full_resume_ack");
        rd(SID, 8'h84, "refill_status");
        ARD_REQ = 1'b0;
        wait_ack(1'b0, "full_ack_low");
        for (int i = 2; i <= 5; i++) begin
            rd(DID, 8'(i), "drain_head");
            strobe(DID, 8'h00);
        end
        rd(SID, 8'h40, "drain_empty");

        // Two-cycle strobe pops once; pop on empty is ignored
        send_byte(8'h11, "hold_fill");
        send_byte(8'h22, "hold_fill");
        rd(SID, 8'h02, "hold_before");
        strobe(DID, 8'h00);
        rd(SID, 8'h01, "hold_after");
        rd(DID, 8'h22, "hold_head");
        strobe(DID, 8'h00);
        strobe(DID, 8'h00);
        rd(SID, 8'h40, "empty_pop");

        // Simultaneous push/pop with pointer wrap
        send_byte(8'h31, "pp_fill");
        send_byte(8'h32, "pp_fill");
        send_byte(8'h33, "pp_fill");
        strobe(DID, 8'h00);
        rd(SID, 8'h02, "pp_pre");
        push_pop(8'h34, "pp_ack1");
        rd(SID, 8'h02, "pp_count1");
        rd(DID, 8'h33, "pp_head1");
        push_pop(8'h35, "pp_ack2");
        rd(SID, 8'h02, "pp_count2");
        rd(DID, 8'h34, "pp_head2");
        strobe(DID, 8'h00);
        rd(DID, 8'h35, "pp_head3");
        strobe(DID, 8'h00);
        rd(SID, 8'h40, "pp_empty");

        // Flush with a concurrent push: push is dropped
        send_byte(8'h41, "fl_fill");
        send_byte(8'h42, "fl_fill");
        send_byte(8'h43, "fl_fill");
        rd(SID, 8'h03, "flush_pre");
        ARD_DATA = 8'h44;
        ARD_REQ  = 1'b1;
        tick(2);
        PORT_ID  = SID;
        OUT_PORT = 8'h01;
        IO_STRB  = 1'b1;
        tick(1);
        expect_v(SEL_ACK, 8'h01, "flush_ack");
        expect_v(SEL_IN, 8'h40, "flush_status");
        tick(1);
        IO_STRB  = 1'b0;
        OUT_PORT = 8'h00;
        ARD_REQ  = 1'b0;
        rd(DID, 8'h00, "flush_data");
        wait_ack(1'b0, "flush_ack_low");
        rd(SID, 8'h40, "flush_final");
        send_byte(8'h55, "post_flush");
        rd(DID, 8'h55, "post_flush_head");
        strobe(DID, 8'h00);

        // Asynchronous reset during WAIT_LOW, then re-push with REQ held
        ARD_DATA = 8'h66;
        ARD_REQ  = 1'b1;
        wait_ack(1'b1, "mid_ack_hi");
        tick(1);
        PORT_ID = SID;
        RST_N   = 1'b0;
        expect_v(SEL_ACK, 8'h00, "rst_async_ack");
        expect_v(SEL_IN, 8'h40, "rst_async_status");
        expect_v(SEL_INTR, 8'h00, "rst_async_intr");
        tick(2);
        RST_N = 1'b1;
        tick(1);
        expect_v(SEL_ACK, 8'h00, "rerun_e1");
        tick(1);
        expect_v(SEL_ACK, 8'h00, "rerun_e2");
        tick(1);
        expect_v(SEL_ACK, 8'h01, "rerun_e3");
        rd(SID, 8'h01, "rerun_status");
        rd(DID, 8'h66, "rerun_head");
        ARD_REQ = 1'b0;
        wait_ack(1'b0, "rerun_ack_low");
        strobe(DID, 8'h00);
        rd(SID, 8'h40, "final_empty");

        PORT_ID = SID;
        #1;
        checks++;
        if (IN_PORT !== 8'h40) begin
            errors++;
            $display("FAIL final_direct_status: got %h, expected 40", IN_PORT);
        end
        checks++;
        if (ARD_ACK !== 1'b0) begin
            errors++;
            $display("FAIL final_direct_ack: got %b, expected 0", ARD_ACK);
        end
        checks++;
        if (INTR !== 1'b0) begin
            errors++;
            $display("FAIL final_direct_intr: got %b, expected 0", INTR);
        end

        tick(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
